serial_flag_alu: RTL and testbench

//   Multi-cycle add/subtract unit that produces the ALU result and V flag consumed by
//   the set-conditional logic (SEQ/SNE/SLT/SGT/SLE/SGE). It is the flag producer on the

---
 rtl/serial_flag_alu.sv | 125 ++++++++++++
 tb/tb_serial_flag_alu.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/serial_flag_alu.sv
// serial_flag_alu: multi-cycle add/subtract (CHUNK bits per cycle) producing result and Z/N/V flags.
// Optional `CMP_CARRY_EN adds output c, the carry-out of the MSB (1 = no borrow on subtract).
module serial_flag_alu #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             n,
  output logic             v
`ifdef CMP_CARRY_EN
  ,
  output logic             c
`endif
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [WIDTH-1:0] r_result;
  logic             r_z;
  logic             r_n;
  logic             r_v;
  logic [CHUNK:0]   w_sum;
  logic             w_cin_msb;
  logic [WIDTH-1:0] w_shift;
  logic             w_accept;
  logic             w_last;

  assign w_accept  = start && (r_state != S_RUN);
  assign w_last    = (r_state == S_RUN) && (r_cnt == LAST);
  assign w_sum     = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
  // Carry into the chunk MSB recovered from the sum bit and the two operand bits.
  assign w_cin_msb = w_sum[CHUNK-1] ^ r_a[CHUNK-1] ^ r_b[CHUNK-1];
  assign w_shift   = (r_acc >> CHUNK) | (WIDTH'(w_sum[CHUNK-1:0]) << (WIDTH - CHUNK));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start  ? S_RUN  : S_IDLE;
      S_RUN:   w_next = w_last ? S_DONE : S_RUN;
      S_DONE:  w_next = start  ? S_RUN  : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  // Operand shift registers need no reset: they are always loaded on an accepted start.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> CHUNK;
      r_b     <= r_b >> CHUNK;
      r_carry <= w_sum[CHUNK];
      r_acc   <= w_shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_result <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_v      <= 1'b0;
    end else begin
      if (w_accept)                  r_cnt <= '0;
      else if (r_state == S_RUN)     r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_result <= w_shift;
        r_z      <= (w_shift == '0);
        r_n      <= w_shift[WIDTH-1];
        r_v      <= w_cin_msb ^ w_sum[CHUNK];
      end
    end
  end

`ifdef CMP_CARRY_EN
  logic r_c;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_c <= 1'b0;
    else if (w_last) r_c <= w_sum[CHUNK];
  end
  assign c = r_c;
`endif

  assign result = r_result;
  assign z      = r_z;
  assign n      = r_n;
  assign v      = r_v;

endmodule

// File: tb/tb_serial_flag_alu.sv
// Directed bench for serial_flag_alu (32-bit, 8-bit chunks) with hand-computed expectations.
module tb_serial_flag_alu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        z;
  logic        n;
  logic        v;
`ifdef CMP_CARRY_EN
  logic        c;
`endif

  int compared = 0;
  int mismatched = 0;
  int lat;
  int pulses;

  serial_flag_alu #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .z(z), .n(n), .v(v)
`ifdef CMP_CARRY_EN
    , .c(c)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one operation at a negedge; it is accepted on the following posedge.
  task automatic launch(input logic s, input logic [31:0] aa, input logic [31:0] bb);
    @(negedge clk);
    sub = s; a = aa; b = bb; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges until done is seen; 20 means it never came.
  task automatic wait_done(output int l);
    l = 0;
    while (l < 20) begin
      @(negedge clk);
      l++;
      if (done) break;
    end
  endtask

  task automatic chk_flags(input string tag, input logic [31:0] r, input logic ez,
                           input logic en, input logic ev, input logic ec);
    chk({tag, "_result"}, result, r);
    chk({tag, "_z"}, {31'd0, z}, {31'd0, ez});
    chk({tag, "_n"}, {31'd0, n}, {31'd0, en});
    chk({tag, "_v"}, {31'd0, v}, {31'd0, ev});
`ifdef CMP_CARRY_EN
    chk({tag, "_c"}, {31'd0, c}, {31'd0, ec});
`else
    if (ec === 1'bx) $display("carry expectation undefined for %s", tag);
`endif
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk_flags("rst", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // T1: 5 - 3
    launch(1'b1, 32'd5, 32'd3);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wait_done(lat);
    chk("t1_latency", lat, 32'd5);
    chk_flags("t1", 32'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t1_done_single", {31'd0, done}, 32'd0);
    chk("t1_busy_idle", {31'd0, busy}, 32'd0);
    chk("t1_hold", result, 32'd2);

    // T2: positive overflow on add
    launch(1'b0, 32'h7FFF_FFFF, 32'd1);
    wait_done(lat);
    chk("t2_latency", lat, 32'd5);
    chk_flags("t2", 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);

    // T3: zero result, then borrow
    launch(1'b1, 32'd3, 32'd3);
    wait_done(lat);
    chk_flags("t3a", 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    launch(1'b1, 32'd0, 32'd1);
    wait_done(lat);
    chk_flags("t3b", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);

    // T4: negative overflow on subtract
    launch(1'b1, 32'h8000_0000, 32'd1);
    wait_done(lat);
    chk_flags("t4", 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);

    // Unsigned wrap on add: carry out, no signed overflow
    launch(1'b0, 32'hFFFF_FFFF, 32'd1);
    wait_done(lat);
    chk_flags("wrap", 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);

    // T5: starts while busy are ignored; first result is delivered
    launch(1'b0, 32'd100, 32'd23);
    @(negedge clk); start = 1'b1; sub = 1'b1; a = 32'd9; b = 32'd9;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; a = 32'd1; b = 32'd2;
    @(negedge clk); start = 1'b0; a = '0; b = '0;
    wait_done(lat);
    chk("t5_done_seen", {31'd0, done}, 32'd1);
    chk_flags("t5a", 32'd123, 1'b0, 1'b0, 1'b0, 1'b0);
    // Back-to-back: start held while done is high
    sub = 1'b1; a = 32'd10; b = 32'd20; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("t5_busy_b2b", {31'd0, busy}, 32'd1);
    wait_done(lat);
    chk("t5_b2b_latency", lat, 32'd5);
    chk_flags("t5b", 32'hFFFF_FFF6, 1'b0, 1'b1, 1'b0, 1'b0);

    // T6: reset mid-operation aborts
    launch(1'b0, 32'd1, 32'd2);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_done", {31'd0, done}, 32'd0);
    chk_flags("t6", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("t6_no_done", pulses, 32'd0);
    launch(1'b1, 32'h10, 32'h4);
    wait_done(lat);
    chk("t6_latency", lat, 32'd5);
    chk_flags("t6_after", 32'hC, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
